fp32_adder_driver: RTL and testbench

Initiator side of the stb/ack operand/result protocol of the team's FP32 adder core. Accepts operand pairs on a valid/ready stream, buffers them in a small FIFO, and issues each pair to the adder core as separate A and B strobe/ack transfers. It then accepts the Z result with its own ack and presents it on a valid/ready result stream. One operation is in flight at a time; results leave in operand order.

---
 rtl/fp32_adder_driver.sv | 160 ++++++++++++++++
 tb/tb_fp32_adder_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp32_adder_driver.sv
// fp32_adder_driver: buffers operand pairs and drives the FP32 adder A/B/Z stb/ack protocol, one op in flight.
// Issue interval 4 + core latency cycles; s_ready_o follows FIFO space; optional WAIT_Z watchdog under FP32_DRV_TIMEOUT_EN.
module fp32_adder_driver #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [31:0] s_a_i,
  input  logic [31:0] s_b_i,
  output logic [31:0] fpu_a_o,
  output logic        fpu_a_stb_o,
  input  logic        fpu_a_ack_i,
  output logic [31:0] fpu_b_o,
  output logic        fpu_b_stb_o,
  input  logic        fpu_b_ack_i,
  input  logic [31:0] fpu_z_i,
  input  logic        fpu_z_stb_i,
  output logic        fpu_z_ack_o,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [31:0] m_z_o,
  output logic        busy_o,
  output logic        timeout_o
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, SEND_A, SEND_B, WAIT_Z} state_t;

  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_ready_q;
  logic          push, pop, z_hs, m_pop;

  state_t        state_q;
  logic [31:0]   a_q, b_q, z_q;
  logic          a_stb_q, b_stb_q, m_valid_q;

`ifdef FP32_DRV_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] to_cnt_q;
  logic          timeout_q;
`endif

  assign push  = s_valid_i && s_ready_q;
  assign pop   = (state_q == IDLE) && (cnt_q != '0);
  assign z_hs  = (state_q == WAIT_Z) && fpu_z_stb_i && (!m_valid_q || m_ready_i);
  assign m_pop = m_valid_q && m_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (push) cnt_d = cnt_d + CW'(1);
    if (pop)  cnt_d = cnt_d - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {s_a_i, s_b_i};
  end

  // Ready is registered from the next count, so a pop never frees space in its own cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q     <= cnt_d;
      s_ready_q <= (cnt_d != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      z_q       <= '0;
      a_stb_q   <= 1'b0;
      b_stb_q   <= 1'b0;
      m_valid_q <= 1'b0;
`ifdef FP32_DRV_TIMEOUT_EN
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      if (z_hs) begin
        z_q       <= fpu_z_i;
        m_valid_q <= 1'b1;
      end else if (m_pop) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pop) begin
            {a_q, b_q} <= mem_q[rd_ptr_q];
            a_stb_q    <= 1'b1;
            state_q    <= SEND_A;
          end
        end
        SEND_A: begin
          if (fpu_a_ack_i) begin
            a_stb_q <= 1'b0;
            b_stb_q <= 1'b1;
            state_q <= SEND_B;
          end
        end
        SEND_B: begin
          if (fpu_b_ack_i) begin
            b_stb_q <= 1'b0;
            state_q <= WAIT_Z;
`ifdef FP32_DRV_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        WAIT_Z: begin
          if (z_hs) begin
            state_q <= IDLE;
          end
`ifdef FP32_DRV_TIMEOUT_EN
          // A strobe blocked only by downstream backpressure is not a stall of the core.
          else if (!fpu_z_stb_i && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end else if (to_cnt_q != TW'(TIMEOUT_CYCLES - 1)) begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready_o   = s_ready_q;
  assign fpu_a_o     = a_q;
  assign fpu_a_stb_o = a_stb_q;
  assign fpu_b_o     = b_q;
  assign fpu_b_stb_o = b_stb_q;
  assign fpu_z_ack_o = z_hs;
  assign m_valid_o   = m_valid_q;
  assign m_z_o       = z_q;
  assign busy_o      = (state_q != IDLE) || (cnt_q != '0);

`ifdef FP32_DRV_TIMEOUT_EN
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_fp32_adder_driver.sv
// Directed bench for fp32_adder_driver with a behavioural adder-core responder (configurable ack delays and z latency).
module tb_fp32_adder_driver;

  logic        clk = 1'b0;
  logic        arst;
  logic        s_valid_i, s_ready_o;
  logic [31:0] s_a_i, s_b_i;
  logic [31:0] fpu_a_o, fpu_b_o, fpu_z_i, m_z_o;
  logic        fpu_a_stb_o, fpu_a_ack_i, fpu_b_stb_o, fpu_b_ack_i;
  logic        fpu_z_stb_i, fpu_z_ack_o;
  logic        m_valid_o, m_ready_i, busy_o, timeout_o;

  fp32_adder_driver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .arst(arst),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_a_i(s_a_i), .s_b_i(s_b_i),
    .fpu_a_o(fpu_a_o), .fpu_a_stb_o(fpu_a_stb_o), .fpu_a_ack_i(fpu_a_ack_i),
    .fpu_b_o(fpu_b_o), .fpu_b_stb_o(fpu_b_stb_o), .fpu_b_ack_i(fpu_b_ack_i),
    .fpu_z_i(fpu_z_i), .fpu_z_stb_i(fpu_z_stb_i), .fpu_z_ack_o(fpu_z_ack_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_z_o(m_z_o),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stand-in for the core's arithmetic: known IEEE vectors, integer sum otherwise.
  function automatic logic [31:0] core_result(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (a == 32'h40A00000 && b == 32'hC0A00000) return 32'h00000000;
    return a + b;
  endfunction

  int          a_dly = 0, b_dly = 0, z_lat = 5;
  bit          z_never = 1'b0;

  initial begin : responder
    int          rs, wcnt, zcnt;
    bit          a_hs, b_hs, z_hs;
    logic [31:0] a_hold, b_hold, a_cap, b_cap;
    rs = 0; wcnt = 0; zcnt = 0;
    a_hold = '0; b_hold = '0; a_cap = '0; b_cap = '0;
    fpu_a_ack_i = 1'b0; fpu_b_ack_i = 1'b0; fpu_z_stb_i = 1'b0; fpu_z_i = '0;
    forever begin
      @(negedge clk);
      a_hs = fpu_a_stb_o && fpu_a_ack_i;
      b_hs = fpu_b_stb_o && fpu_b_ack_i;
      z_hs = fpu_z_ack_o;
      @(posedge clk);
      #1;
      fpu_a_ack_i = 1'b0;
      fpu_b_ack_i = 1'b0;
      if (arst) begin
        rs = 0; wcnt = 0; zcnt = 0; fpu_z_stb_i = 1'b0;
      end else begin
        if (rs == 3 && z_hs) begin
          fpu_z_stb_i = 1'b0;
          rs = 0;
        end
        if (rs == 0 && a_hs) begin
          chk("a_stb_drop", 64'(fpu_a_stb_o), 64'h0);
          rs = 1; wcnt = 0;
        end
        if (rs == 1 && b_hs) begin
          chk("b_stb_drop", 64'(fpu_b_stb_o), 64'h0);
          rs = z_never ? 0 : 2; wcnt = 0; zcnt = 0;
        end
        if (rs == 2) begin
          zcnt++;
          if (zcnt >= z_lat) begin
            fpu_z_i = core_result(a_cap, b_cap);
            fpu_z_stb_i = 1'b1;
            rs = 3;
          end
        end
        if (rs == 0 && fpu_a_stb_o) begin
          if (wcnt == 0) a_hold = fpu_a_o;
          else chk("a_stable", 64'(fpu_a_o), 64'(a_hold));
          if (wcnt >= a_dly) begin fpu_a_ack_i = 1'b1; a_cap = fpu_a_o; end
          else wcnt++;
        end
        if (rs == 1 && fpu_b_stb_o) begin
          if (wcnt == 0) b_hold = fpu_b_o;
          else chk("b_stable", 64'(fpu_b_o), 64'(b_hold));
          if (wcnt >= b_dly) begin fpu_b_ack_i = 1'b1; b_cap = fpu_b_o; end
          else wcnt++;
        end
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int  n;
    bit  rdy;
    s_a_i = a; s_b_i = b; s_valid_i = 1'b1;
    n = 0;
    while (!s_ready_o && n < 200) begin tick(); n++; end
    rdy = s_ready_o;
    tick();
    s_valid_i = 1'b0;
    chk("push_accept", 64'(rdy), 64'h1);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!m_valid_o && n < 150) begin tick(); n++; end
    chk(tag, 64'(m_valid_o), 64'h1);
  endtask

  initial begin : main
    int n;
    arst = 1'b1; s_valid_i = 1'b0; s_a_i = '0; s_b_i = '0; m_ready_i = 1'b0;
    tick(); tick();
    chk("rst_flags", 64'({fpu_a_stb_o, fpu_b_stb_o, fpu_z_ack_o, m_valid_o, s_ready_o, busy_o, timeout_o}), 64'h0);
    chk("rst_data", {fpu_a_o, fpu_b_o}, 64'h0);
    #2 arst = 1'b0;
    tick();
    chk("ready_after_rst", 64'(s_ready_o), 64'h1);

    // Single op, immediate acks, z after 5 cycles.
    s_a_i = 32'h3F800000; s_b_i = 32'h40000000; s_valid_i = 1'b1;
    tick();
    s_valid_i = 1'b0;
    chk("t1_no_stb_yet", 64'(fpu_a_stb_o), 64'h0);
    chk("t1_busy", 64'(busy_o), 64'h1);
    tick();
    chk("t1_a_stb", 64'(fpu_a_stb_o), 64'h1);
    chk("t1_a_dat", 64'(fpu_a_o), 64'h3F800000);
    tick();
    chk("t1_a_stb_1cyc", 64'(fpu_a_stb_o), 64'h0);
    chk("t1_b_stb", 64'(fpu_b_stb_o), 64'h1);
    chk("t1_b_dat", 64'(fpu_b_o), 64'h40000000);
    repeat (5) tick();
    chk("t1_mvalid_n7", 64'(m_valid_o), 64'h0);
    tick();
    chk("t1_mvalid_n8", 64'(m_valid_o), 64'h1);
    chk("t1_z", 64'(m_z_o), 64'h40400000);
    m_ready_i = 1'b1;
    tick();
    chk("t1_popped", 64'(m_valid_o), 64'h0);
    chk("t1_idle", 64'(busy_o), 64'h0);

    // Stalled acks.
    a_dly = 3; b_dly = 2;
    push(32'h00000011, 32'h00000022);
    wait_valid("t2_valid");
    chk("t2_z", 64'(m_z_o), 64'h33);
    tick();
    a_dly = 0; b_dly = 0;

    // Backpressure: 6 pairs with downstream stalled.
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) push(32'h100 + 32'(i), 32'h200 + 32'(i));
    repeat (30) tick();
    chk("bp_full", 64'(s_ready_o), 64'h0);
    chk("bp_zstb", 64'(fpu_z_stb_i), 64'h1);
    chk("bp_zack_held", 64'(fpu_z_ack_o), 64'h0);
    chk("bp_first", 64'(m_z_o), 64'h300);

    // Full FIFO: push offered during the pop cycle is accepted one cycle later.
    s_a_i = 32'h106; s_b_i = 32'h206; s_valid_i = 1'b1;
    m_ready_i = 1'b1;
    tick();
    m_ready_i = 1'b0;
    chk("ff_e1_ready", 64'(s_ready_o), 64'h0);
    chk("ff_e1_idle", 64'(fpu_a_stb_o), 64'h0);
    chk("ff_e1_z", 64'(m_z_o), 64'h302);
    tick();
    chk("ff_e2_pop", 64'(fpu_a_stb_o), 64'h1);
    chk("ff_e2_a", 64'(fpu_a_o), 64'h102);
    chk("ff_e2_ready", 64'(s_ready_o), 64'h1);
    tick();
    s_valid_i = 1'b0;
    chk("ff_e3_full", 64'(s_ready_o), 64'h0);
    m_ready_i = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      wait_valid("drain_valid");
      chk("drain_z", 64'(m_z_o), 64'(32'h300 + 32'(2 * k)));
      tick();
    end
    repeat (3) tick();
    chk("drain_idle", 64'(busy_o), 64'h0);

    // Reset while in WAIT_Z with a second pair queued.
    z_lat = 40;
    push(32'h11, 32'h22);
    push(32'h33, 32'h44);
    n = 0;
    while (!fpu_b_stb_o && n < 50) begin tick(); n++; end
    tick(); tick();
    chk("mr_busy", 64'(busy_o), 64'h1);
    #2 arst = 1'b1;
    #1;
    chk("mr_flags", 64'({fpu_a_stb_o, fpu_b_stb_o, fpu_z_ack_o, m_valid_o, s_ready_o, busy_o, timeout_o}), 64'h0);
    chk("mr_data", {fpu_a_o, fpu_b_o}, 64'h0);
    chk("mr_mz", 64'(m_z_o), 64'h0);
    @(posedge clk); @(posedge clk);
    #3 arst = 1'b0;
    tick();
    chk("mr_flushed", 64'(busy_o), 64'h0);
    z_lat = 5;
    push(32'h40A00000, 32'hC0A00000);
    wait_valid("mr_valid");
    chk("mr_z", 64'(m_z_o), 64'h0);
    tick();
    repeat (5) tick();
    chk("mr_single_result", 64'({busy_o, m_valid_o}), 64'h0);

`ifdef FP32_DRV_TIMEOUT_EN
    z_never = 1'b1;
    push(32'h55, 32'h66);
    n = 0;
    while (!fpu_b_stb_o && n < 50) begin tick(); n++; end
    tick();
    chk("to_in_waitz", 64'(fpu_b_stb_o), 64'h0);
    repeat (9) tick();
    chk("to_not_yet", 64'(timeout_o), 64'h0);
    tick();
    chk("to_set", 64'(timeout_o), 64'h1);
    chk("to_idle", 64'({busy_o, m_valid_o}), 64'h0);
    z_never = 1'b0;
    push(32'h3F800000, 32'h40000000);
    wait_valid("to_next_valid");
    chk("to_next_z", 64'(m_z_o), 64'h40400000);
    chk("to_sticky", 64'(timeout_o), 64'h1);
    tick();
`else
    chk("timeout_tied", 64'(timeout_o), 64'h0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
